// File: rtl/decode_pkg.sv
// Shared definitions for decode_unit: opcodes, mux/ALU encodings, the decoded
// control bundle and the FSM state type.
// Optional feature macro: DECODE_IMM_ALU_EN (opcode 4'hA decodes as ADDI).
package decode_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned NZP_W = 3;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_BR    = 4'h1;
  localparam logic [OPC_W-1:0] OP_CMP   = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_MUL   = 4'h5;
  localparam logic [OPC_W-1:0] OP_DIV   = 4'h6;
  localparam logic [OPC_W-1:0] OP_LDR   = 4'h7;
  localparam logic [OPC_W-1:0] OP_STR   = 4'h8;
  localparam logic [OPC_W-1:0] OP_CONST = 4'h9;
  localparam logic [OPC_W-1:0] OP_ADDI  = 4'hA;
  localparam logic [OPC_W-1:0] OP_RET   = 4'hF;

  typedef enum logic [1:0] {
    RIM_ALU = 2'b00,
    RIM_LSU = 2'b01,
    RIM_IMM = 2'b10
  } reg_in_mux_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_ctl_e;

  // Control part of one decoded op; register fields and imm are appended by
  // the top because their widths are parameters.
  typedef struct packed {
    logic              reg_write_enable;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic              nzp_write_enable;
    reg_in_mux_e       reg_input_mux;
    alu_ctl_e          alu_control;
    logic              alu_output_mux;
    logic              alu_src_imm;
    logic              next_pc_mux;
    logic              decoded_ret;
    logic              dec_illegal;
    logic [NZP_W-1:0]  nzp;
  } dec_ctrl_t;

  localparam int unsigned CTRL_W = $bits(dec_ctrl_t);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } dec_state_e;

  // Full bundle width: control + rd/rs/rt + imm.
  function automatic int unsigned bundle_w(input int unsigned reg_w, input int unsigned imm_w);
    return CTRL_W + 3 * reg_w + imm_w;
  endfunction

endpackage

// File: rtl/decode_fifo2.sv
// Two-entry skid FIFO holding decoded bundles.
// Ports: clk, reset_n (async active-low), flush (empties, wins over push),
//        push/push_data, pop, count (0..2), valid (count != 0),
//        head (oldest entry, all-zero when empty).
module decode_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && (count != 2'd2) && !flush;
  assign pop_ok  = pop  && (count != 2'd0) && !flush;

  // Pointer and occupancy tracking; flush resets everything in one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign valid = (count != 2'd0);
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/decode_unit.sv
// miniGPU instruction decoder with valid/ready on both sides, a two-entry
// output FIFO, halt-after-RET, illegal-opcode flagging and a saturating
// decode counter.
// Optional feature macro: DECODE_IMM_ALU_EN -- opcode 4'hA decodes as ADDI
//   (imm = rt field, alu_src_imm = 1); undefined, opcode 4'hA is illegal.
// Ports: clk, reset_n, start, flush; fetch side instr_valid/instr/instr_ready;
//        decode side dec_valid/dec_ready plus the decoded fields of the FIFO
//        head; status err_illegal, halted, decode_count.
module decode_unit
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned IMM_W      = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic                  instr_valid,
  input  logic [INSTR_W-1:0]    instr,
  output logic                  instr_ready,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic [REG_ADDR_W-1:0] rt_addr,
  output logic [IMM_W-1:0]      imm,
  output logic [2:0]            decoded_nzp,
  output logic                  reg_write_enable,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic                  nzp_write_enable,
  output logic [1:0]            reg_input_mux,
  output logic [1:0]            alu_control,
  output logic                  alu_output_mux,
  output logic                  alu_src_imm,
  output logic                  next_pc_mux,
  output logic                  decoded_ret,
  output logic                  dec_illegal,
  output logic                  err_illegal,
  output logic                  halted,
  output logic [CNT_W-1:0]      decode_count
);

  localparam int unsigned FLD_W    = 3 * REG_ADDR_W + IMM_W;
  localparam int unsigned BUNDLE_W = bundle_w(REG_ADDR_W, IMM_W);
  localparam int unsigned RD_HI    = INSTR_W - OPC_W - 1;

  dec_state_e            state_q, state_d;
  logic [OPC_W-1:0]      opcode_c;
  logic [REG_ADDR_W-1:0] rd_c, rs_c, rt_c;
  logic [IMM_W-1:0]      imm_c;
  dec_ctrl_t             ctrl_c;
  logic                  push;
  logic                  pop;
  logic [1:0]            fifo_count;
  logic [BUNDLE_W-1:0]   head;
  dec_ctrl_t             head_ctrl;

  // Instruction field extraction.
  assign opcode_c = instr[INSTR_W-1 -: OPC_W];
  assign rd_c     = instr[RD_HI -: REG_ADDR_W];
  assign rs_c     = instr[RD_HI - REG_ADDR_W -: REG_ADDR_W];
  assign rt_c     = instr[RD_HI - 2 * REG_ADDR_W -: REG_ADDR_W];

  // Combinational opcode decode; unknown opcodes leave every enable low.
  always_comb begin
    ctrl_c     = '0;
    ctrl_c.nzp = instr[RD_HI -: NZP_W];
    imm_c      = instr[IMM_W-1:0];
    case (opcode_c)
      OP_NOP: ;
      OP_BR:  ctrl_c.next_pc_mux = 1'b1;
      OP_CMP: begin
        ctrl_c.alu_control      = ALU_SUB;
        ctrl_c.alu_output_mux   = 1'b1;
        ctrl_c.nzp_write_enable = 1'b1;
      end
      OP_ADD: ctrl_c.reg_write_enable = 1'b1;
      OP_SUB: begin
        ctrl_c.reg_write_enable = 1'b1;
        ctrl_c.alu_control      = ALU_SUB;
      end
      OP_MUL: begin
        ctrl_c.reg_write_enable = 1'b1;
        ctrl_c.alu_control      = ALU_MUL;
      end
      OP_DIV: begin
        ctrl_c.reg_write_enable = 1'b1;
        ctrl_c.alu_control      = ALU_DIV;
      end
      OP_LDR: begin
        ctrl_c.reg_write_enable = 1'b1;
        ctrl_c.mem_read_enable  = 1'b1;
        ctrl_c.reg_input_mux    = RIM_LSU;
      end
      OP_STR: ctrl_c.mem_write_enable = 1'b1;
      OP_CONST: begin
        ctrl_c.reg_write_enable = 1'b1;
        ctrl_c.reg_input_mux    = RIM_IMM;
      end
`ifdef DECODE_IMM_ALU_EN
      OP_ADDI: begin
        ctrl_c.reg_write_enable = 1'b1;
        ctrl_c.alu_src_imm      = 1'b1;
        imm_c                   = IMM_W'(rt_c);
      end
`endif
      OP_RET: ctrl_c.decoded_ret = 1'b1;
      default: ctrl_c.dec_illegal = 1'b1;
    endcase
  end

  assign instr_ready = (state_q == ST_RUN) && (fifo_count < 2'd2);
  // A flush drops any op offered in the same cycle.
  assign push        = instr_valid && instr_ready && !flush;
  assign pop         = dec_valid && dec_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // Next-state logic: RET intake halts, start or flush resumes.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:    if (push && ctrl_c.decoded_ret) state_d = ST_HALTED;
        ST_HALTED: if (start) state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // Sticky illegal flag (a new illegal op beats start) and saturating counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_illegal  <= 1'b0;
      decode_count <= '0;
    end else begin
      if (push && ctrl_c.dec_illegal) err_illegal <= 1'b1;
      else if (start)                 err_illegal <= 1'b0;
      if (push && (decode_count != {CNT_W{1'b1}}))
        decode_count <= decode_count + CNT_W'(1);
    end
  end

  decode_fifo2 #(
    .W (BUNDLE_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data ({ctrl_c, rd_c, rs_c, rt_c, imm_c}),
    .pop       (pop),
    .count     (fifo_count),
    .valid     (dec_valid),
    .head      (head)
  );

  // Unpack the FIFO head onto the decoded output ports.
  assign head_ctrl        = head[BUNDLE_W-1 -: CTRL_W];
  assign rd_addr          = head[FLD_W-1 -: REG_ADDR_W];
  assign rs_addr          = head[FLD_W-1-REG_ADDR_W -: REG_ADDR_W];
  assign rt_addr          = head[IMM_W+REG_ADDR_W-1 -: REG_ADDR_W];
  assign imm              = head[IMM_W-1:0];
  assign decoded_nzp      = head_ctrl.nzp;
  assign reg_write_enable = head_ctrl.reg_write_enable;
  assign mem_read_enable  = head_ctrl.mem_read_enable;
  assign mem_write_enable = head_ctrl.mem_write_enable;
  assign nzp_write_enable = head_ctrl.nzp_write_enable;
  assign reg_input_mux    = head_ctrl.reg_input_mux;
  assign alu_control      = head_ctrl.alu_control;
  assign alu_output_mux   = head_ctrl.alu_output_mux;
  assign alu_src_imm      = head_ctrl.alu_src_imm;
  assign next_pc_mux      = head_ctrl.next_pc_mux;
  assign decoded_ret      = head_ctrl.decoded_ret;
  assign dec_illegal      = head_ctrl.dec_illegal;
  assign halted           = (state_q == ST_HALTED);

endmodule
